// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// one bit per cycle, with single-cycle fast path for divide-by-zero and signed overflow.
module mdu_iter #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    localparam int unsigned CNT_W = 6;
    localparam int unsigned RD_W  = 5;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   result_d;
    logic [RD_W-1:0]   rd_out_d;
    logic              done_d;

    // Operand decode for the instruction presented in IDLE
    logic              a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b;

    assign a_neg = ((funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
                    (funct3_i == F3_DIV)  || (funct3_i == F3_REM)) && op_a_i[XLEN-1];
    assign b_neg = ((funct3_i == F3_MULH) || (funct3_i == F3_DIV) ||
                    (funct3_i == F3_REM)) && op_b_i[XLEN-1];
    assign mag_a    = a_neg ? -op_a_i : op_a_i;
    assign mag_b    = b_neg ? -op_b_i : op_b_i;
    assign div_zero = funct3_i[2] && (op_b_i == '0);
    assign div_ovf  = funct3_i[2] && !funct3_i[0] && (op_a_i == INT_MIN) && (op_b_i == '1);

    // One iteration step: hi holds product-high / partial remainder, lo holds multiplier / quotient
    logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fix_res;

    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    assign rem_sh   = {hi_q, lo_q[XLEN-1]};
    assign rem_diff = rem_sh - {1'b0, opb_q};
    assign prod     = {hi_q, lo_q};
    assign prod_s   = neg_q ? -prod : prod;
    assign quo_s    = neg_q ? -lo_q : lo_q;
    assign rem_s    = neg_q ? -hi_q : hi_q;

    always_comb begin
        fix_res = rem_s;
        case (f3_q)
            F3_MUL:                        fix_res = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  fix_res = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               fix_res = quo_s;
            default:                       fix_res = rem_s;
        endcase
    end

    assign busy_o = !flush_i && (((state_q == IDLE) && start_i) ||
                                 (state_q == CALC) || (state_q == FIX));

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        result_d = result_o;
        rd_out_d = rd_o;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    f3_d = funct3_i;
                    rd_d = rd_i;
                    if (div_zero) begin
                        result_d = funct3_i[1] ? op_a_i : '1;
                        rd_out_d = rd_i;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else if (div_ovf) begin
                        result_d = funct3_i[1] ? '0 : INT_MIN;
                        rd_out_d = rd_i;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        cnt_d   = '0;
                        hi_d    = '0;
                        lo_d    = mag_a;
                        opb_d   = mag_b;
                        neg_d   = (funct3_i == F3_REM) ? a_neg : (a_neg ^ b_neg);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (f3_q[2]) begin
                    hi_d = rem_diff[XLEN] ? rem_sh[XLEN-1:0] : rem_diff[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], !rem_diff[XLEN]};
                end else begin
                    hi_d = mul_sum[XLEN:1];
                    lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = fix_res;
                rd_out_d = rd_q;
                done_d   = 1'b1;
                state_d  = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A flush discards whatever is in flight and leaves the visible result intact
        if (flush_i) begin
            state_d  = IDLE;
            done_d   = 1'b0;
            result_d = result_o;
            rd_out_d = rd_o;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            result_o <= '0;
            rd_o     <= '0;
            done_o   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            result_o <= result_d;
            rd_o     <= rd_out_d;
            done_o   <= done_d;
        end
    end

endmodule
